// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing {hi, lo}, one bit per cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier and skip CALC.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               idle_like;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign accept    = start_i & idle_like & ~cancel_i;
    assign stall_o   = accept | (state == CALC) | (state == FIX);
    assign signed_op = ~op_i[0];
    assign abs_a     = (signed_op & a_i[WIDTH-1]) ? -a_i : a_i;
    assign abs_b     = (signed_op & b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] fast_prod;

    assign ext_a     = {{WIDTH{signed_op & a_i[WIDTH-1]}}, a_i};
    assign ext_b     = {{WIDTH{signed_op & b_i[WIDTH-1]}}, b_i};
    assign fast_prod = ext_a * ext_b;
`endif

    // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
        acc_next  = {mul_sum, acc[WIDTH-1:1]};
        if (op_q[1]) begin
            if (!rem_diff[WIDTH])
                acc_next = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // A zero divisor yields an all-ones quotient; the remainder naturally reproduces a.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (mag_b == '0)
            quot_fix = '1;
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (op_q[1]) begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mag_b   <= '0;
            acc     <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= op_i;
                        mag_b   <= abs_b;
                        neg_rem <= signed_op & a_i[WIDTH-1];
                        busy_o  <= 1'b1;
                        acc     <= {{WIDTH{1'b0}}, abs_a};
                        cnt     <= CNT_W'(WIDTH);
                        state   <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                        neg_res <= signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & op_i[1];
                        if (!op_i[1]) begin
                            acc   <= fast_prod;
                            cnt   <= '0;
                            state <= FIX;
                        end
`else
                        neg_res <= signed_op & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    state  <= cancel_i ? IDLE : DONE;
                    busy_o <= 1'b0;
                    if (!cancel_i) begin
                        hi_o   <= res_hi;
                        lo_o   <= res_lo;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit (WIDTH=32 main instance, WIDTH=16 side instance).
module tb_muldiv_unit;
    localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT   = 2;
    localparam int MUL16_LAT = 2;
`else
    localparam int MUL_LAT   = 34;
    localparam int MUL16_LAT = 18;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    logic        start16;
    logic [1:0]  op16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cancel16;
    logic        stall16;
    logic        busy16;
    logic        done16;
    logic [15:0] hi16;
    logic [15:0] lo16;

    logic [63:0] exp_q[$];
    logic [63:0] last_res;
    int          vectors = 0;
    int          errors  = 0;

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .cancel_i(cancel_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    muldiv_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start_i(start16), .op_i(op16), .a_i(a16), .b_i(b16),
        .cancel_i(cancel16), .stall_o(stall16), .busy_o(busy16), .done_o(done16),
        .hi_o(hi16), .lo_o(lo16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input string item, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %h expected %h", tag, item, obs, exp);
        end
    endtask

    // Reference arithmetic: 64-bit products and SV truncating division.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        int     ia;
        int     ib;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = a;
        ib = b;
        case (op)
            2'b00: r = sa * sb;
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    r = {32'd0, 32'h8000_0000};
                else
                    r = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int lat, input int pulse_cyc);
        logic [63:0] exp;
        int cyc;
        bit seen;
        bit busy_bad;
        exp_q.push_back(exp_res);
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        check(tag, "stall_start", 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        seen = 1'b0; busy_bad = 1'b0; cyc = 0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                cyc  = k;
            end else if (!busy_o || !stall_o) begin
                busy_bad = 1'b1;
            end
            start_i = (k == pulse_cyc);
        end
        start_i = 1'b0;
        check(tag, "done_seen", 64'(seen), 64'd1);
        check(tag, "latency", 64'(cyc), 64'(lat));
        check(tag, "busy", 64'(busy_bad), 64'd0);
        exp = exp_q.pop_front();
        check(tag, "result", {hi_o, lo_o}, exp);
        last_res = exp;
        @(negedge clk);
        check(tag, "done_pulse", 64'(done_o), 64'd0);
        check(tag, "hold", {hi_o, lo_o}, exp);
    endtask

    task automatic quiet(input string tag, input int n, input logic [63:0] exp_res);
        int dones;
        dones = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check(tag, "no_done", 64'(dones), 64'd0);
        check(tag, "hold", {hi_o, lo_o}, exp_res);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          cyc16;

        rst = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; cancel_i = 1'b0;
        start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0; cancel16 = 1'b0;
        last_res = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", "result", {hi_o, lo_o}, 64'd0);
        check("reset", "flags", {61'd0, done_o, busy_o, stall_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_op("mult_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, 0);
        run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_LAT, 0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT, 0);
        run_op("div_-7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_LAT, 0);
        run_op("divu_5_0", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_LAT, 10);
        quiet("divu_5_0_pulse", 40, {32'd5, 32'hFFFF_FFFF});
        run_op("div_-5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, DIV_LAT, 0);

        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
            if (r_b == 32'd0) r_b = 32'd1;
            run_op("random", r_op, r_a, r_b, model(r_op, r_a, r_b), r_op[1] ? DIV_LAT : MUL_LAT, 0);
        end

        // Cancel mid-divide: previous result must survive.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd50; b_i = 32'd3;
        @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel", "busy", 64'(busy_o), 64'd0);
        check("cancel", "stall", 64'(stall_o), 64'd0);
        quiet("cancel", 40, last_res);

        // Start and cancel together: ignored.
        @(posedge clk); #1;
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        check("start_cancel", "stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        @(negedge clk);
        check("start_cancel", "busy", 64'(busy_o), 64'd0);
        quiet("start_cancel", 40, last_res);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= 20; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_reset", "result", {hi_o, lo_o}, 64'd0);
        check("mid_reset", "flags", {62'd0, done_o, busy_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        quiet("mid_reset", 40, 64'd0);
        run_op("after_reset", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT, 0);

        // WIDTH=16 instance: MULT 300 * -2.
        @(posedge clk); #1;
        start16 = 1'b1; op16 = 2'b00; a16 = 16'd300; b16 = 16'hFFFE;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc16 = 0;
        for (int k = 1; k <= 60 && cyc16 == 0; k++) begin
            @(negedge clk);
            if (done16) cyc16 = k;
        end
        check("mult16", "latency", 64'(cyc16), 64'(MUL16_LAT));
        check("mult16", "result", {32'd0, hi16, lo16}, 64'h0000_0000_FFFF_FDA8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
